// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller with on-the-fly key expansion.
// Datapath: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey, one round per clk.
// Byte k of a 128-bit block lives at [127-8k -: 8]; column c holds bytes 4c..4c+3.

// Single AES S-box lane: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x12, x15, x240, inv;

    // Addition chain for x^254 = x^240 * x^12 * x^2 (0 maps to 0)
    always_comb begin
        x2   = gmul(din, din);
        x3   = gmul(x2, din);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        inv  = gmul(gmul(x240, x12), x2);
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         busy,
    output logic [3:0]   round
);
    if (NR != 10) begin : g_nr_check
        $error("aes_round_ctrl: only NR=10 (AES-128) is supported");
    end

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t fsm, fsm_nxt;

    logic [127:0] state_reg, key_reg;
    logic [127:0] sr_flat, mc_flat, rnd_out;
    logic [15:0][7:0] sb_in, sb_out, sr, mc;
    logic [31:0] rot_w, sub_w, rk_w0, rk_w1, rk_w2, rk_w3;
    logic [127:0] rk;
    logic last;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // State-path S-box lanes and byte (un)packing
    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign sb_in[k] = state_reg[127-8*k -: 8];
        aes_sbox u_sbox (.din(sb_in[k]), .dout(sb_out[k]));
        assign sr_flat[127-8*k -: 8] = sr[k];
        assign mc_flat[127-8*k -: 8] = mc[k];
    end

    // ShiftRows: row r rotates left by r columns
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c+r] = sb_out[4*((c+r)%4)+r];
        end
        assign mc[4*c+0] = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
        assign mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
    end

    // Key schedule: dedicated SubWord S-boxes, not shared with the state path
    assign rot_w = {key_reg[23:0], key_reg[31:24]};
    for (genvar j = 0; j < 4; j++) begin : g_ksbox
        aes_sbox u_ksbox (.din(rot_w[8*j +: 8]), .dout(sub_w[8*j +: 8]));
    end
    assign rk_w0 = key_reg[127:96] ^ sub_w ^ {rcon(round), 24'h0};
    assign rk_w1 = rk_w0 ^ key_reg[95:64];
    assign rk_w2 = rk_w1 ^ key_reg[63:32];
    assign rk_w3 = rk_w2 ^ key_reg[31:0];
    assign rk    = {rk_w0, rk_w1, rk_w2, rk_w3};

    assign last    = (round == LAST);
    assign rnd_out = (last ? sr_flat : mc_flat) ^ rk;

    assign in_ready = (fsm == IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    // FSM next-state decode
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (in_valid) fsm_nxt = RUN;
            RUN:     if (last) fsm_nxt = DONE;
            DONE:    if (out_ready) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // Datapath, round counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= '0;
            key_reg   <= '0;
            round     <= '0;
            out_valid <= 1'b0;
            out_text  <= '0;
            busy      <= 1'b0;
        end else begin
            busy      <= (fsm_nxt != IDLE);
            out_valid <= (fsm_nxt == DONE);
            case (fsm)
                IDLE: if (in_valid) begin
                    state_reg <= in_text ^ in_key;
                    key_reg   <= in_key;
                    round     <= 4'd1;
                end
                RUN: begin
                    state_reg <= rnd_out;
                    key_reg   <= rk;
                    if (last) out_text <= rnd_out;
                    else      round    <= round + 4'd1;
                end
                DONE: if (out_ready) round <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: FIPS-197 vectors, backpressure,
// back-to-back, mid-block reset and randomized blocks against a table-based model.
module tb_aes_round_ctrl;
    logic         clk;
    logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_text, in_key, out_text;
    logic [3:0]   round;

    int total = 0;
    int fails = 0;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_C   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RK1_C = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    logic [7:0] sbox_t [256];

    aes_round_ctrl #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
        .busy(busy), .round(round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from exp/log tables over generator 3
    function automatic void build_sbox();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] p, b;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = p;
            lg[p] = i;
            p = gm(p, 8'h03);
        end
        for (int x = 0; x < 256; x++) begin
            b = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c+0] = gm(t[4*c],2) ^ gm(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1],2) ^ gm(t[4*c+2],3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2],2) ^ gm(t[4*c+3],3);
                    s[4*c+3] = gm(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3],2);
                end else begin
                    for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one block in IDLE, then wait (bounded) for out_valid
    task automatic run_block(input logic [127:0] t, input logic [127:0] k,
                             output logic [127:0] ct, output int lat);
        in_text = t; in_key = k; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        ct = out_text;
    endtask

    initial begin
        logic [127:0] ct, ex, held, got;
        int lat, n, cyc, n_acc;
        int acc [2];
        logic ok, done, seen;
        logic [127:0] outs [$];

        build_sbox();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_text = '0; in_key = '0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_round", round, 0);
        chk("rst_out_text", out_text, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);

        // FIPS-197 App. B
        out_ready = 1'b1;
        run_block(PT_B, K_B, ct, lat);
        chk("B_latency", lat, 10);
        chk("B_ct", ct, CT_B);
        chk("B_round", round, 10);
        tick();
        chk("B_pulse", out_valid, 0);
        chk("B_in_ready", in_ready, 1);
        chk("B_round_clr", round, 0);

        // FIPS-197 App. C.1 with round-key probe
        in_text = PT_C; in_key = K_C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("C_round1", round, 1);
        chk("C_busy", busy, 1);
        chk("C_in_ready", in_ready, 0);
        tick();
        chk("C_rk1", dut.key_reg, RK1_C);
        n = 1;
        while (!out_valid && n < 40) begin tick(); n++; end
        chk("C_latency", n, 10);
        chk("C_ct", out_text, CT_C);
        tick();
        chk("C_pulse", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        ct = rnd128(); held = rnd128();
        ex = aes_ref(ct, held);
        run_block(ct, held, got, lat);
        chk("bp_ct", got, ex);
        held = out_text;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin in_valid = 1'b1; in_text = rnd128(); in_key = rnd128(); end
            else in_valid = 1'b0;
            tick();
            if (!(out_valid === 1'b1 && out_text === held && in_ready === 1'b0 && round === 4'd10))
                ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_hold", ok, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("bp_no_ghost", ok, 1);

        // Back-to-back with in_valid held high
        in_text = PT_B; in_key = K_B; in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0; cyc = 0; acc[0] = 0; acc[1] = 0;
        while (cyc < 80 && (n_acc < 2 || outs.size() < 2)) begin
            if (in_valid && in_ready) begin acc[n_acc] = cyc; n_acc++; end
            if (out_valid && out_ready) outs.push_back(out_text);
            tick();
            cyc++;
            if (n_acc == 1) begin in_text = PT_C; in_key = K_C; end
            if (n_acc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("b2b_count", outs.size(), 2);
        chk("b2b_ct0", (outs.size() > 0) ? outs[0] : 128'hx, CT_B);
        chk("b2b_ct1", (outs.size() > 1) ? outs[1] : 128'hx, CT_C);
        chk("b2b_spacing", acc[1] - acc[0], 12);
        tick();

        // Reset during round 5
        in_text = PT_B; in_key = K_B; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round != 4'd5 && n < 20) begin tick(); n++; end
        chk("mid_reached_r5", round, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_round", round, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_in_ready", in_ready, 1);
        run_block(PT_B, K_B, ct, lat);
        chk("mid_after_ct", ct, CT_B);
        tick();

        // Random blocks with noisy inputs and random out_ready
        for (int it = 0; it < 6; it++) begin
            ct = rnd128(); held = rnd128();
            ex = aes_ref(ct, held);
            in_text = ct; in_key = held; in_valid = 1'b1; out_ready = 1'b0;
            tick();
            n = 0; done = 1'b0; seen = 1'b0; ok = 1'b1; got = '0;
            while (!done && n < 100) begin
                in_text = rnd128(); in_key = rnd128();
                in_valid = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid) begin
                    if (!seen) begin got = out_text; seen = 1'b1; end
                    else if (out_text !== got) ok = 1'b0;
                    if (out_ready) begin in_valid = 1'b0; done = 1'b1; end
                end
                tick();
                n++;
            end
            in_valid = 1'b0;
            chk($sformatf("rnd%0d_ct", it), got, ex);
            chk($sformatf("rnd%0d_done", it), {done, ok}, 2'b11);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption core controller: accepts one plaintext block and cipher key, sequences 10 rounds through the team's SubBytes, ShiftRows, mix_cols and AddRoundKey datapath, and produces the ciphertext.
- Round keys are expanded on the fly, one per round.
- Sits between the block-level valid/ready interface and the combinational round datapath.
- One round executes per clock; one block is in flight at a time.

Parameters:
NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is a synthesis error.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous reset, active low.
in_valid  input  1  plaintext/key valid.
in_ready  output  1  controller can accept a block (high only in IDLE).
in_text  input  128  plaintext, FIPS-197 byte order, byte 0 in [127:120], column-major (same as mix_cols din).
in_key  input  128  cipher key, same byte order.
out_valid  output  1  ciphertext valid.
out_ready  input  1  downstream accepts ciphertext.
out_text  output  128  ciphertext, same byte order.
busy  output  1  high in RUN or DONE.
round  output  4  current round index 0..10, for debug.

Behaviour:
- Reset: all sampled on clk edge with rst_n=0. State=IDLE, in_ready=1 (from the cycle after reset deasserts), out_valid=0, busy=0, round=0, out_text=0, state and key registers=0. Reset mid-block discards the block with no output.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid&in_ready, state_reg <= in_text ^ in_key (round 0 AddRoundKey), key_reg <= in_key, round <= 1, go to RUN.
  - RUN: each cycle:
    - compute rk = next round key from key_reg using rcon[round]: rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10. rk_w0 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,00,00,00}; rk_wi = rk_w(i-1) ^ wi.
    - state_reg <= AddRoundKey(MixCols(ShiftRows(SubBytes(state_reg))), rk). Round 10 bypasses mix_cols.
    - key_reg <= rk.
    - round increments. After the round 10 update, go to DONE with round held at 10.
  - DONE: out_valid=1, out_text=state_reg, held stable until out_ready=1. On out_valid&out_ready, go to IDLE, out_valid=0, round=0.
- Latency: acceptance at cycle T gives out_valid high at T+11, i.e. 10 RUN cycles then DONE. Throughput: at most one block per 12 cycles (IDLE accept, 10 RUN, DONE handshake). A block can be accepted in the cycle immediately after the DONE handshake.
- Handshake rules:
  - in_valid while not in IDLE is ignored; in_ready=0 and no capture occurs.
  - Changes to in_text/in_key while in_ready=0 have no effect.
  - out_ready while out_valid=0 has no effect.
  - out_ready held high at DONE entry: handshake completes in the first DONE cycle.
- Round counter never exceeds 10; no wrap is allowed.
- The SubWord S-box is a combinational lookup, separate from the state-path S-boxes; no resource sharing.
- All outputs come directly from registers except in_ready, which is decoded from the state register only.

Test Plan:
- FIPS-197 App. B: in_text=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_valid exactly 11 cycles after accept, out_text=3925841d02dc09fbdc118597196a0b32, one-cycle pulse.
- FIPS-197 App. C.1: in_text=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f -> out_text=69c4e0d86a7b0430d8cdb78070b4c55a. Check round key 1 = d6aa74fdd2af72fadaa678f1d6ab76fe via probe.
- Backpressure: out_ready=0 for 20 cycles after completion -> out_valid and out_text held constant; in_ready=0; a second in_valid pulse is ignored. Release out_ready -> in_ready=1 next cycle.
- Back-to-back: in_valid held high with the App. B then App. C.1 vectors, out_ready=1 -> both ciphertexts correct in order; second accept occurs exactly 12 cycles after the first.
- Reset mid-operation: assert rst_n=0 during RUN round 5 for 1 cycle -> next cycle state IDLE, out_valid=0, round=0, busy=0. A fresh App. B block then produces the correct ciphertext.
- Input stability: toggle in_text/in_key randomly during RUN -> ciphertext matches the values captured at accept.
